// File: rtl/trigger_debouncer.sv
// Trigger debouncer: a 2-FF synchroniser feeds a stability-count FSM.
// db_out changes only after the synced input has held a new level for
// STABLE_CYCLES consecutive cycles. The block also produces one-cycle
// rise/fall strobes, a busy flag and a saturating count of aborted
// qualifications.
module trigger_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter bit RESET_LEVEL   = 1'b0,
  parameter int BCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_raw,
  input  logic              bcnt_clr,
  output logic              db_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
  output logic [BCNT_W-1:0] bounce_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;
  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic              s1_q, s1_d, s2_q, s2_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              db_q, db_d;
  logic              rise_q, rise_d, fall_q, fall_d;
  logic              busy_q, busy_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              bounce;
  logic              sync;

  assign sync = s2_q;

  // Next-state logic: synchroniser shift, qualification FSM, strobes, bounce counter
  always_comb begin
    s1_d    = trig_raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    bounce  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          bounce  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          db_d    = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          bounce  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          db_d    = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    // Clear wins over a coincident bounce; the count sticks at all-ones
    if (bcnt_clr)
      bcnt_d = '0;
    else if (bounce && (bcnt_q != '1))
      bcnt_d = bcnt_q + BCNT_W'(1);
    else
      bcnt_d = bcnt_q;
  end

  // State register; reset lands on the idle level with no strobe pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= RESET_LEVEL;
      s2_q    <= RESET_LEVEL;
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      db_q    <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign bounce_cnt = bcnt_q;

endmodule

// File: tb/tb_trigger_debouncer.sv
// Bench for trigger_debouncer (STABLE_CYCLES=4, RESET_LEVEL=0, BCNT_W=8).
// A run-length reference model predicts every output each cycle; a vector
// table and hand-written sequences pin down latency and counter corners.
module tb_trigger_debouncer;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig_raw = 1'b0;
  logic       bcnt_clr = 1'b0;
  logic       db_out, rise_pulse, fall_pulse, busy;
  logic [7:0] bounce_cnt;

  trigger_debouncer #(.STABLE_CYCLES(S), .RESET_LEVEL(1'b0), .BCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .trig_raw(trig_raw), .bcnt_clr(bcnt_clr),
    .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .busy(busy), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_rise = 0;

  // Reference model: pipeline of raw samples plus length of the current
  // run of synced samples that disagree with the debounced level.
  logic       m_s1, m_s2, m_db, m_rise, m_fall;
  int         m_run;
  logic [7:0] m_bcnt;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_bcnt = 8'd0;
  endtask

  task automatic model_step(input logic trig, input logic clr);
    logic sync;
    logic bounce;
    sync = m_s2;
    bounce = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (sync != m_db) begin
      m_run++;
      if (m_run == S) begin
        m_db = sync;
        if (sync) m_rise = 1'b1; else m_fall = 1'b1;
        m_run = 0;
      end
    end else begin
      if (m_run > 0) bounce = 1'b1;
      m_run = 0;
    end
    if (clr) m_bcnt = 8'd0;
    else if (bounce && m_bcnt < 8'd255) m_bcnt = m_bcnt + 8'd1;
    m_s2 = m_s1;
    m_s1 = trig;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [31:0] act, exp;
    act = {20'd0, db_out, rise_pulse, fall_pulse, busy, bounce_cnt};
    exp = {20'd0, m_db, m_rise, m_fall, (m_run > 0), m_bcnt};
    chk(name, act, exp);
    chk("rise_fall_exclusive", {31'd0, rise_pulse & fall_pulse}, 32'd0);
  endtask

  // One cycle: drive inputs, advance the model on the edge, compare mid-cycle
  task automatic tick(input logic trig, input logic clr);
    trig_raw = trig;
    bcnt_clr = clr;
    @(posedge clk);
    if (rst_n) model_step(trig, clr);
    @(negedge clk);
    chk_model("model");
    if (rise_pulse) n_rise++;
  endtask

  task automatic do_reset(input int cycles, input logic trig);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("async_reset");
    repeat (cycles) tick(trig, 1'b0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       trig;
    logic       db, rise, fall, bsy;
    logic [7:0] bcnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int first_hi;
    int hold, lvl;

    // Clean rise then clean fall, one row per edge starting at capture edge E0
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Reset and idle hold
    @(negedge clk);
    do_reset(3, 1'b0);
    chk("reset_outputs", {27'd0, db_out, rise_pulse, fall_pulse, busy, (bounce_cnt != 0)}, 32'd0);
    repeat (20) tick(1'b0, 1'b0);
    chk("idle_outputs", {24'd0, db_out, rise_pulse, fall_pulse, busy, 4'd0}, 32'd0);
    chk("idle_bcnt", {24'd0, bounce_cnt}, 32'd0);

    // Vector table: clean rise and clean fall
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].trig, 1'b0);
      chk($sformatf("vec%0d", i),
          {20'd0, db_out, rise_pulse, fall_pulse, busy, bounce_cnt},
          {20'd0, vecs[i].db, vecs[i].rise, vecs[i].fall, vecs[i].bsy, vecs[i].bcnt});
    end

    // Bounce: high 2, low 3, then high; rise lands 5 edges after final capture
    n_rise = 0;
    first_hi = -1;
    for (int i = 0; i < 16; i++) begin
      tick((i < 2 || i >= 5) ? 1'b1 : 1'b0, 1'b0);
      if (db_out && first_hi < 0) first_hi = i;
    end
    chk("bounce_rise_edge", first_hi, 32'd10);
    chk("bounce_one_strobe", n_rise, 32'd1);
    chk("bounce_cnt_1", {24'd0, bounce_cnt}, 32'd1);

    // Reset mid-WAIT_HI, then full requalification
    repeat (10) tick(1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    n_rise = 0;
    do_reset(2, 1'b1);
    chk("midrst_state", {29'd0, db_out, busy, rise_pulse}, 32'd0);
    first_hi = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (db_out && first_hi < 0) first_hi = i;
    end
    chk("requal_edge", first_hi, 32'd5);
    chk("requal_one_strobe", n_rise, 32'd1);

    // Saturate the bounce counter
    repeat (10) tick(1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0);
    chk("bcnt_saturate", {24'd0, bounce_cnt}, 32'd255);
    tick(1'b0, 1'b1);
    chk("bcnt_clear", {24'd0, bounce_cnt}, 32'd0);
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("bcnt_after_one", {24'd0, bounce_cnt}, 32'd1);
    // Clear coincides with the bounce edge (third edge after capture)
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
    chk("bcnt_clr_priority", {24'd0, bounce_cnt}, 32'd0);

    // Randomised runs checked against the model
    lvl = 0;
    for (int i = 0; i < 600; i++) begin
      hold = $urandom_range(1, 8);
      lvl = $urandom_range(0, 1);
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 2), lvl[0]);
        else tick(lvl[0], ($urandom_range(0, 49) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
